// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: registers tagged commands onto the ALU pins, captures the result one cycle later
// into a response FIFO (rsp_valid two edges after accept); cmd_ready reserves a slot for the in-flight entry.

module alu_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_op_a,
  output logic [7:0]       alu_op_b,
  output logic [2:0]       alu_op,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic             busy
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]       result;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             illegal;
  } rsp_t;

  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_a_q, s1_a_d;
  logic [7:0]       s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic          accept;
  logic          pop;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  rsp_t          push_dat;
  rsp_t          head_dat;

  // Occupancy counts the in-flight entry so its push always has a slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
  assign cmd_ready = occupancy < (CW+1)'(DEPTH);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    if (accept) begin
      s1_a_d   = cmd_a;
      s1_b_d   = cmd_b;
      s1_op_d  = cmd_op;
      s1_tag_d = cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  assign alu_op_a = s1_a_q;
  assign alu_op_b = s1_b_q;
  assign alu_op   = s1_op_q;

  assign push_dat.result  = alu_result;
  assign push_dat.tag     = s1_tag_q;
  assign push_dat.zero    = (alu_result == 8'h00);
  assign push_dat.illegal = s1_op_q[2] & s1_op_q[1];

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  alu_cmd_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (s1_valid_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (fifo_count)
  );

  // Gate the head so an empty FIFO presents all-zero response fields.
  assign rsp_result  = rsp_valid ? head_dat.result  : 8'h00;
  assign rsp_tag     = rsp_valid ? head_dat.tag     : '0;
  assign rsp_zero    = rsp_valid & head_dat.zero;
  assign rsp_illegal = rsp_valid & head_dat.illegal;

  assign busy = s1_valid_q || rsp_valid;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU model on the alu_* pins.
module tb_alu_cmd_issuer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_tag;
  logic [7:0] alu_op_a, alu_op_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_tag;
  logic       rsp_zero, rsp_illegal, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000: alu_result = alu_op_a + alu_op_b;
      3'b001: alu_result = alu_op_a - alu_op_b;
      3'b010: alu_result = alu_op_a & alu_op_b;
      3'b011: alu_result = alu_op_a | alu_op_b;
      3'b100: alu_result = alu_op_a ^ alu_op_b;
      3'b101: alu_result = ~alu_op_a;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [3:0] tag;
    logic [7:0] res;
    logic       z, il;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int   accepted, exp_tag;
  logic stale;

  initial begin
    vecs[0]  = '{3'b001, 8'h00, 8'h01, 4'd1,  8'hFF, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 8'hFF, 8'h01, 4'd2,  8'h00, 1'b1, 1'b0};
    vecs[2]  = '{3'b101, 8'h0F, 8'h33, 4'd3,  8'hF0, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 8'hF0, 8'h3C, 4'd4,  8'h30, 1'b0, 1'b0};
    vecs[4]  = '{3'b011, 8'h0F, 8'h30, 4'd5,  8'h3F, 1'b0, 1'b0};
    vecs[5]  = '{3'b100, 8'hAA, 8'hFF, 4'd6,  8'h55, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 8'h55, 8'hAA, 4'd7,  8'h00, 1'b1, 1'b1};
    vecs[7]  = '{3'b000, 8'h01, 8'h02, 4'd8,  8'h03, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 8'h12, 8'h34, 4'd9,  8'h00, 1'b1, 1'b1};
    vecs[9]  = '{3'b001, 8'h05, 8'h05, 4'd10, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{3'b000, 8'h80, 8'h7F, 4'd15, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00; cmd_tag = 4'h0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_op_a", alu_op_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    rst_n = 1'b1;

    // Single ADD: latency and fields
    @(negedge clk);
    drive(3'b000, 8'h12, 8'h34, 4'd3);
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("t1_not_yet_valid", rsp_valid, 0);
    check("t1_alu_op_a", alu_op_a, 8'h12);
    check("t1_alu_op_b", alu_op_b, 8'h34);
    check("t1_alu_op", alu_op, 3'b000);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_valid", rsp_valid, 1);
    check("t1_result", rsp_result, 8'h46);
    check("t1_tag", rsp_tag, 3);
    check("t1_zero", rsp_zero, 0);
    @(negedge clk);
    check("t1_drained", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // Back-to-back table: response k is at the head two negedges after it is driven
    for (int k = 0; k < NV + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("tbl%0d_valid", k-2), rsp_valid, 1);
        check($sformatf("tbl%0d_result", k-2), rsp_result, vecs[k-2].res);
        check($sformatf("tbl%0d_tag", k-2), rsp_tag, vecs[k-2].tag);
        check($sformatf("tbl%0d_zero", k-2), rsp_zero, vecs[k-2].z);
        check($sformatf("tbl%0d_illegal", k-2), rsp_illegal, vecs[k-2].il);
      end
      if (k < NV) begin
        check($sformatf("tbl%0d_ready", k), cmd_ready, 1);
        drive(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].tag);
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("tbl_drained", rsp_valid, 0);

    // Backpressure: stream 6 commands with rsp_ready low
    rsp_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (accepted < 6) begin
        drive(3'b000, 8'(accepted), 8'h10, 4'(accepted));
        if (cmd_ready) accepted++;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check("bp_accepted", accepted, 4);
    check("bp_cmd_ready_low", cmd_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_hold_tag", rsp_tag, 0);
    check("bp_hold_result", rsp_result, 8'h10);

    // Full FIFO with cmd_valid and rsp_ready together, then drain in order
    exp_tag = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) check("full_not_ready", cmd_ready, 0);
      if (c == 1) check("full_pop_then_ready", cmd_ready, 1);
      if (rsp_valid) begin
        check($sformatf("ord%0d_tag", exp_tag), rsp_tag, exp_tag);
        check($sformatf("ord%0d_result", exp_tag), rsp_result, exp_tag + 16);
        exp_tag++;
      end
      if (accepted < 6) begin
        drive(3'b000, 8'(accepted), 8'h10, 4'(accepted));
        if (cmd_ready) accepted++;
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = 1'b1;
    end
    check("ord_count", exp_tag, 6);
    check("ord_idle", busy, 0);

    // Reset with two buffered responses and one in flight
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'b000, 8'(i), 8'h01, 4'(8 + i));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_rsp_valid", rsp_valid, 1);
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_rsp_tag", rsp_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    stale = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stale = 1'b1;
    end
    check("arst_no_stale", stale, 0);
    drive(3'b000, 8'h07, 8'h08, 4'd12);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_result", rsp_result, 8'h0F);
    check("post_rst_tag", rsp_tag, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
